// File: rtl/button_conditioner.sv
// button_conditioner
//   Input-conditioning stage in front of the device FSM. The raw active-low
//   push-button and the raw mode switch are each synchronized into clk and
//   then debounced with a stable-count filter. The block also makes one-cycle
//   press/release pulses from the debounced button level, so that a single
//   physical press advances the FSM exactly once.
//
// Parameters
//   SYNC_STAGES      synchronizer flops per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing synced samples needed before the
//                    stable value follows the input (>= 1)
//   CNT_W            debounce counter width (derived)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   button_raw  in   raw push-button pin, active-low, idles 1
//   mode_raw    in   raw mode switch pin
//   button      out  debounced button level, active-low
//   mode        out  debounced mode level
//   press       out  one-cycle pulse on a debounced 1->0 of button
//   release_o   out  one-cycle pulse on a debounced 0->1 of button
//                    (named release_o because `release` is a reserved word)
module button_conditioner #(
    parameter int  SYNC_STAGES     = 2,
    parameter int  DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    input  logic mode_raw,
    output logic button,
    output logic mode,
    output logic press,
    output logic release_o
);

    // Count value on which the next differing sample commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] mode_sync_q;
    logic                   btn_synced;
    logic                   mode_synced;

    logic                   btn_stable_q;
    logic                   btn_stable_d;
    logic [CNT_W-1:0]       btn_cnt_q;
    logic [CNT_W-1:0]       btn_cnt_d;

    logic                   mode_stable_q;
    logic                   mode_stable_d;
    logic [CNT_W-1:0]       mode_cnt_q;
    logic [CNT_W-1:0]       mode_cnt_d;

    // Previous debounced button level for edge detection.
    logic                   btn_hist_q;

    assign btn_synced  = btn_sync_q[SYNC_STAGES-1];
    assign mode_synced = mode_sync_q[SYNC_STAGES-1];

    // Debounce: any sample that matches the stable level clears the count, so
    // only an unbroken run of DEBOUNCE_CYCLES differing samples gets through.
    always_comb begin
        btn_stable_d = btn_stable_q;
        btn_cnt_d    = '0;
        if (btn_synced != btn_stable_q) begin
            if (btn_cnt_q == CNT_LAST) begin
                btn_stable_d = btn_synced;
            end else begin
                btn_cnt_d = btn_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mode_stable_d = mode_stable_q;
        mode_cnt_d    = '0;
        if (mode_synced != mode_stable_q) begin
            if (mode_cnt_q == CNT_LAST) begin
                mode_stable_d = mode_synced;
            end else begin
                mode_cnt_d = mode_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync_q    <= '1;
            mode_sync_q   <= '0;
            btn_stable_q  <= 1'b1;
            mode_stable_q <= 1'b0;
            btn_cnt_q     <= '0;
            mode_cnt_q    <= '0;
            btn_hist_q    <= 1'b1;
        end else begin
            btn_sync_q    <= {btn_sync_q[SYNC_STAGES-2:0], button_raw};
            mode_sync_q   <= {mode_sync_q[SYNC_STAGES-2:0], mode_raw};
            btn_stable_q  <= btn_stable_d;
            mode_stable_q <= mode_stable_d;
            btn_cnt_q     <= btn_cnt_d;
            mode_cnt_q    <= mode_cnt_d;
            btn_hist_q    <= btn_stable_q;
        end
    end

    assign button    = btn_stable_q;
    assign mode      = mode_stable_q;

    // Both operands are flops, so the pulses are glitch-free and land in the
    // first cycle the debounced button shows its new level.
    assign press     = btn_hist_q & ~btn_stable_q;
    assign release_o = ~btn_hist_q & btn_stable_q;

endmodule
